qspi_mem_responder: RTL and testbench

Synthesisable quad-SPI memory responder: the device end of the SoC's shared QSPI flash/PSRAM bus. It oversamples `sclk`, `cs_n` and `io_in` on its own fast clock, decodes quad-mode command/address frames and serves reads and writes from an internal byte-wide RAM. It stands in for external flash or PSRAM, both on FPGA builds and as a synthesisable bench model. A backdoor load port preloads program images.

---
 rtl/qspi_pkg.sv | 25 ++
 rtl/qspi_resp_ram.sv | 33 +++
 rtl/qspi_mem_responder.sv | 252 +++++++++++++++++++++++++
 tb/tb_qspi_mem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared definitions for the quad-SPI memory responder: command codes,
// frame nibble counts and the responder state encoding.
package qspi_pkg;

    localparam logic [7:0] QSPI_CMD_QREAD  = 8'hEB;
    localparam logic [7:0] QSPI_CMD_QWRITE = 8'h38;

    localparam logic [7:0] QSPI_CMD_NIB  = 8'd2;
    localparam logic [7:0] QSPI_ADDR_NIB = 8'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } qspi_resp_state_t;

    function automatic logic qspi_cmd_supported(input logic [7:0] cmd);
        return (cmd == QSPI_CMD_QREAD) || (cmd == QSPI_CMD_QWRITE);
    endfunction

endpackage

// File: rtl/qspi_resp_ram.sv
// Dual-port 2^AW x 8 synchronous RAM: port A serves frame reads/writes with
// one-cycle read latency, port B is the backdoor loader. Port A wins collisions.
module qspi_resp_ram #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_wdata,
    output logic [7:0]    a_rdata,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_wdata
);

    logic [7:0] mem [0:(1<<AW)-1];

    // NOTE: the array has no reset branch; clearing 2^AW entries is not
    // buildable as RAM, and preloaded images must survive a responder reset.
    always_ff @(posedge clk) begin
        if (a_en && a_we) begin
            mem[a_addr] <= a_wdata;
        end
        if (b_we && !(a_en && a_we && (a_addr == b_addr))) begin
            mem[b_addr] <= b_wdata;
        end
        if (a_en && !a_we) begin
            a_rdata <= mem[a_addr];
        end
    end

endmodule

// File: rtl/qspi_mem_responder.sv
// Quad-SPI flash/PSRAM device model serving 0xEB reads and 0x38 writes from
// an internal RAM. Optional output delay line: define QSPI_RESP_OUT_DELAY_EN.
module qspi_mem_responder
    import qspi_pkg::*;
#(
    parameter int AW           = 16,
    parameter int DUMMY_CYCLES = 6
`ifdef QSPI_RESP_OUT_DELAY_EN
    ,
    parameter int OUT_DELAY    = 0
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          cs_n,
    input  logic [3:0]    io_in,
    output logic [3:0]    io_out,
    output logic [3:0]    io_oe,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          busy,
    output logic          cmd_err
);

    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    logic          sclk_s1, sclk_s2, sclk_s3;
    logic          cs_s1, cs_s2;
    logic [3:0]    io_s1, io_s2;
    logic [1:0]    sync_vld;
    logic          rise, fall;

    qspi_resp_state_t state, state_nxt;

    logic [7:0]    cnt;
    logic [3:0]    cmd_sr;
    logic [7:0]    cmd_full;
    logic          is_write;
    logic [AW-5:0] addr_sh;
    logic [AW-1:0] new_addr;
    logic [AW-1:0] addr;
    logic [3:0]    wr_hi;
    logic          half;
    logic          nib_lo;
    logic [3:0]    rd_nib;
    logic          oe_act;
    logic          armed;
    logic          cmd_err_nxt;
    logic          addr_done, fetch, prefetch, wr_byte;

    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_rdata;

    logic [3:0]    out_q;
    logic          oe_q;

    // NOTE: every register here uses <= so all stages sample the previous
    // cycle's values; blocking assignments would collapse the synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_s3  <= 1'b0;
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            io_s1    <= '0;
            io_s2    <= '0;
            sync_vld <= '0;
        end else begin
            sclk_s1  <= sclk;
            sclk_s2  <= sclk_s1;
            sclk_s3  <= sclk_s2;
            cs_s1    <= cs_n;
            cs_s2    <= cs_s1;
            io_s1    <= io_in;
            io_s2    <= io_s1;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    assign rise     = sclk_s2 & ~sclk_s3;
    assign fall     = ~sclk_s2 & sclk_s3;
    assign cmd_full = {cmd_sr, io_s2};
    assign new_addr = {addr_sh, io_s2};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaults come first so no path leaves an output unassigned,
    // which would otherwise infer latches.
    always_comb begin
        state_nxt   = state;
        cmd_err_nxt = 1'b0;
        addr_done   = 1'b0;
        fetch       = 1'b0;
        prefetch    = 1'b0;
        wr_byte     = 1'b0;
        if (cs_s2) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (armed) state_nxt = ST_CMD;
                end
                ST_CMD: begin
                    if (rise && cnt == QSPI_CMD_NIB - 8'd1) begin
                        if (qspi_cmd_supported(cmd_full)) begin
                            state_nxt = ST_ADDR;
                        end else begin
                            state_nxt   = ST_IGNORE;
                            cmd_err_nxt = 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise && cnt == QSPI_ADDR_NIB - 8'd1) begin
                        addr_done = 1'b1;
                        if (is_write) begin
                            state_nxt = ST_WDATA;
                        end else begin
                            fetch     = 1'b1;
                            state_nxt = (DUMMY_CYCLES == 0) ? ST_RDATA : ST_DUMMY;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (rise && cnt == DUMMY_LAST) state_nxt = ST_RDATA;
                end
                ST_RDATA: begin
                    prefetch = fall && nib_lo;
                end
                ST_WDATA: begin
                    wr_byte = rise && half;
                end
                default: ;
            endcase
        end
    end

    // A new frame may only start after cs_n has been seen high on settled sync flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            cmd_sr   <= '0;
            is_write <= 1'b0;
            addr_sh  <= '0;
            addr     <= '0;
            wr_hi    <= '0;
            half     <= 1'b0;
            nib_lo   <= 1'b0;
            rd_nib   <= '0;
            oe_act   <= 1'b0;
            cmd_err  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            cmd_err <= cmd_err_nxt;
            if (cs_s2 && sync_vld[1]) armed <= 1'b1;
            if (cs_s2) begin
                cnt    <= '0;
                half   <= 1'b0;
                nib_lo <= 1'b0;
                oe_act <= 1'b0;
            end else begin
                if (rise && (state == ST_CMD || state == ST_ADDR || state == ST_DUMMY)) begin
                    cnt <= (state_nxt != state) ? '0 : cnt + 8'd1;
                end
                if (rise && state == ST_CMD) begin
                    cmd_sr   <= io_s2;
                    is_write <= (cmd_full == QSPI_CMD_QWRITE);
                end
                if (rise && state == ST_ADDR) addr_sh <= new_addr[AW-5:0];
                if (addr_done) begin
                    addr <= new_addr;
                end else if (prefetch || wr_byte) begin
                    addr <= addr + AW'(1);
                end
                if (rise && state == ST_WDATA) begin
                    half <= ~half;
                    if (!half) wr_hi <= io_s2;
                end
                if (fall && state == ST_RDATA) begin
                    rd_nib <= nib_lo ? ram_rdata[3:0] : ram_rdata[7:4];
                    nib_lo <= ~nib_lo;
                    oe_act <= 1'b1;
                end
            end
        end
    end

    assign ram_en   = fetch | prefetch | wr_byte;
    assign ram_we   = wr_byte;
    assign ram_addr = fetch ? new_addr : (prefetch ? addr + AW'(1) : addr);

    qspi_resp_ram #(.AW(AW)) u_ram (
        .clk     (clk),
        .a_en    (ram_en),
        .a_we    (ram_we),
        .a_addr  (ram_addr),
        .a_wdata ({wr_hi, io_s2}),
        .a_rdata (ram_rdata),
        .b_we    (ld_we),
        .b_addr  (ld_addr),
        .b_wdata (ld_data)
    );

    // Output register: cs_n high drops io_oe without waiting for the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            oe_q  <= 1'b0;
        end else begin
            oe_q  <= oe_act & ~cs_s2;
            out_q <= (oe_act & ~cs_s2) ? rd_nib : 4'h0;
        end
    end

`ifdef QSPI_RESP_OUT_DELAY_EN
    logic [4:0] dly  [3];
    logic [4:0] taps [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {oe_q, out_q};
            dly[1] <= dly[0];
            dly[2] <= dly[1];
        end
    end

    assign taps[0] = {oe_q, out_q};
    assign taps[1] = dly[0];
    assign taps[2] = dly[1];
    assign taps[3] = dly[2];
    assign io_out  = taps[OUT_DELAY][3:0];
    assign io_oe   = {4{taps[OUT_DELAY][4]}};
`else
    assign io_out = out_q;
    assign io_oe  = {4{oe_q}};
`endif

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Self-checking bench for qspi_mem_responder: drives quad frames as the
// initiator and scores read nibbles against a byte-model scoreboard.
module tb_qspi_mem_responder;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          cs_n;
    logic [3:0]    io_in;
    logic [3:0]    io_out;
    logic [3:0]    io_oe;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          busy;
    logic          cmd_err;

    int n_tests = 0;
    int n_fail  = 0;
    int err_pulses = 0;
    int oe_cycles  = 0;

    logic [3:0] exp_q [$];
    logic [7:0] model [int];

    always #5 clk = ~clk;

    qspi_mem_responder #(.AW(AW), .DUMMY_CYCLES(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .io_in   (io_in),
        .io_out  (io_out),
        .io_oe   (io_oe),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    always @(negedge clk) begin
        if (cmd_err === 1'b1) err_pulses++;
        if (io_oe !== 4'h0) oe_cycles++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sclk_cycle(input logic [3:0] nib, output logic [3:0] s_out, output logic [3:0] s_oe);
        io_in = nib;
        repeat (8) @(negedge clk);
        s_out = io_out;
        s_oe  = io_oe;
        sclk  = 1'b1;
        repeat (8) @(negedge clk);
        sclk  = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] nib);
        logic [3:0] o, e;
        sclk_cycle(nib, o, e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) send_nib(a[4*i +: 4]);
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic end_frame();
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_we   = 1'b0;
        model[int'(a)] = d;
    endtask

    task automatic read_frame(input logic [23:0] a, input int n_nib, input bit keep_open);
        logic [AW-1:0] ba;
        logic [7:0]    b;
        logic [3:0]    o, oe, e;
        for (int i = 0; i < n_nib; i++) begin
            ba = a[AW-1:0] + AW'(i / 2);
            b  = model[int'(ba)];
            exp_q.push_back((i % 2 == 0) ? b[7:4] : b[3:0]);
        end
        start_frame();
        send_byte(8'hEB);
        send_addr(a);
        for (int i = 0; i < 6; i++) begin
            sclk_cycle(4'h0, o, oe);
            if (i == 5) check("dummy_oe", oe, 4'h0);
        end
        for (int i = 0; i < n_nib; i++) begin
            sclk_cycle(4'h0, o, oe);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: got empty queue, expected entry");
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rd_%0h_n%0d", a, i), o, e);
            end
            check($sformatf("rd_oe_%0h_n%0d", a, i), oe, 4'hF);
        end
        if (!keep_open) end_frame();
    endtask

    task automatic write_frame(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
        start_frame();
        send_byte(8'h38);
        send_addr(a);
        send_byte(b0);
        send_byte(b1);
        end_frame();
        model[int'(a[AW-1:0])]          = b0;
        model[int'(a[AW-1:0] + AW'(1))] = b1;
    endtask

    initial begin
        int err0, oe0;
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; io_in = 4'h0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        check("rst_io_out", io_out, 4'h0);
        check("rst_io_oe", io_oe, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_err", cmd_err, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        load(16'h0010, 8'hA5);
        load(16'h0011, 8'h3C);
        load(16'h0012, 8'h0F);
        load(16'h0013, 8'hF0);
        read_frame(24'h000010, 8, 1'b0);

        write_frame(24'h000200, 8'h12, 8'h34);
        read_frame(24'h000200, 4, 1'b0);

        err0 = err_pulses;
        oe0  = oe_cycles;
        start_frame();
        send_byte(8'h05);
        check("ign_busy", busy, 1'b1);
        send_addr(24'h000010);
        send_byte(8'h12);
        send_byte(8'h34);
        end_frame();
        check("ign_cmd_err", 8'(err_pulses - err0), 8'd1);
        check("ign_oe", 8'(oe_cycles - oe0), 8'd0);
        read_frame(24'h000010, 4, 1'b0);

        read_frame(24'h000010, 3, 1'b1);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_oe", io_oe, 4'h0);
        end_frame();
        read_frame(24'h000010, 2, 1'b0);

        load(16'hFFFF, 8'h77);
        load(16'h0000, 8'h88);
        read_frame(24'h00FFFF, 4, 1'b0);

        load(16'h0301, 8'h66);
        start_frame();
        send_byte(8'h38);
        send_addr(24'h000300);
        send_byte(8'h5A);
        send_nib(4'hC);
        model[int'(16'h0300)] = 8'h5A;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_oe", io_oe, 4'h0);
        check("mid_rst_out", io_out, 4'h0);
        send_nib(4'h3);
        check("post_rst_idle", busy, 1'b0);
        end_frame();
        read_frame(24'h000300, 4, 1'b0);
        write_frame(24'h000400, 8'h9E, 8'h21);
        read_frame(24'h000400, 4, 1'b0);

        check("sb_drain", 8'(exp_q.size()), 8'd0);
        check("cmd_err_total", 8'(err_pulses), 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
